// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register that sits directly in front of the ALU.
// It captures the decoded operands and control bits from ID. It then resolves
// EX/MEM and MEM/WB forwarding and drives alu_op, in1 and in2 into the ALU.
// It also detects load-use hazards, inserts bubbles, and honours a global
// stall and a branch flush.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall, flush        global hold / flush of the instruction entering EX
//   id_*                decoded instruction fields from ID
//   exmem_*, memwb_*    forwarding sources (write enable, destination, data)
//   ex_*                captured / forwarded values toward the ALU and MEM
//   load_use_hazard     to IF/ID: hold PC and IF/ID this cycle
//
// Handshake: there is no valid/ready pair. ex_valid qualifies the EX outputs.
// load_use_hazard is the only backpressure, and it applies in the same cycle.
// stall holds every stage at once, so nothing is lost while it is high.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [3:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic              id_is_shift,
  input  logic [4:0]        id_shamt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd_addr,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd_addr,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              load_use_hazard
);

  // Captured operand state that is not visible directly on the ports.
  logic [REG_AW-1:0] ex_rs_addr;
  logic [REG_AW-1:0] ex_rt_addr;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_shamt;
  logic              ex_use_imm;
  logic              ex_is_shift;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic              rt_is_read;
  logic              rs_hit;
  logic              rt_hit;

  // Load-use detection. A shift does not read rs. rt is read by R-type ops,
  // by shifts and by stores, whose store data comes from rt.
  always_comb begin
    rt_is_read      = !id_use_imm || id_is_shift || id_mem_write;
    rs_hit          = !id_is_shift && (id_rs_addr == ex_rd_addr);
    rt_hit          = rt_is_read && (id_rt_addr == ex_rd_addr);
    load_use_hazard = !flush && ex_valid && ex_mem_read &&
                      (ex_rd_addr != '0) && id_valid && (rs_hit || rt_hit);
  end

  // Forwarding. EX/MEM is younger, so it wins over MEM/WB.
  // Register 0 always reads as zero, whatever is on the buses.
  always_comb begin
    fwd_rs = ex_rs_data;
    if (ex_rs_addr == '0)
      fwd_rs = '0;
    else if (exmem_reg_write && (exmem_rd_addr == ex_rs_addr))
      fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd_addr == ex_rs_addr))
      fwd_rs = memwb_data;

    fwd_rt = ex_rt_data;
    if (ex_rt_addr == '0)
      fwd_rt = '0;
    else if (exmem_reg_write && (exmem_rd_addr == ex_rt_addr))
      fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd_addr == ex_rt_addr))
      fwd_rt = memwb_data;
  end

  // Operand selection toward the ALU.
  always_comb begin
    ex_in1        = fwd_rs;
    ex_in2        = fwd_rt;
    ex_store_data = fwd_rt;
    if (ex_is_shift) begin
      ex_in1 = fwd_rt;
      ex_in2 = {{(DATA_W-5){1'b0}}, ex_shamt};
    end else if (ex_use_imm) begin
      ex_in2 = ex_imm;
    end
  end

  // Pipeline register. Priority: flush, then stall, then hazard bubble, then load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= 4'd0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_rd_addr   <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_shamt     <= 5'd0;
      ex_use_imm   <= 1'b0;
      ex_is_shift  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (flush || (!stall && load_use_hazard)) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= 4'd0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_rd_addr   <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_shamt     <= 5'd0;
      ex_use_imm   <= 1'b0;
      ex_is_shift  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      ex_alu_op    <= id_alu_op;
      ex_rs_addr   <= id_rs_addr;
      ex_rt_addr   <= id_rt_addr;
      ex_rd_addr   <= id_rd_addr;
      ex_rs_data   <= id_rs_data;
      ex_rt_data   <= id_rt_data;
      ex_imm       <= id_imm;
      ex_shamt     <= id_shamt;
      ex_use_imm   <= id_use_imm;
      ex_is_shift  <= id_is_shift;
      // An invalid slot must never write state downstream.
      ex_reg_write <= id_valid && id_reg_write;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_mem_write <= id_valid && id_mem_write;
    end
  end

endmodule
